// File: rtl/gs232c_fetch_packer.sv
// Instruction fetch packer: issues 16 B line fetches, pairs in-order cache returns with their pc and
// buffers packets for decode. Optional perf counters when GS232C_FETCH_PERF_EN is defined.
module gs232c_fetch_packer #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clock,
   input  logic         resetn,
   output logic         fe_req,
   output logic [31:0]  fe_pc,
   input  logic         fe_ack,
   input  logic         ic_valid,
   input  logic [127:0] ic_inst,
   input  logic         ic_uncache,
   output logic         i_valid,
   output logic [31:0]  i_pc,
   output logic [127:0] i_inst,
   output logic [1:0]   i_count,
   output logic [29:0]  i_seq,
   output logic [29:0]  i_target,
   output logic         i_is_seq,
   output logic         i_uncache,
   output logic [15:0]  i_hint,
   input  logic         i_ready,
   input  logic         pr_cancel,
   input  logic [31:0]  pr_target,
   input  logic         br_redirect,
   input  logic [31:0]  br_target,
   input  logic         stall
`ifdef GS232C_FETCH_PERF_EN
   ,
   output logic [31:0]  perf_req_cnt,
   output logic [31:0]  perf_pkt_cnt,
   output logic [31:0]  perf_drop_cnt,
   output logic [31:0]  perf_redirect_cnt
`endif
);

   // state   | meaning
   // ST_BOOT | first cycle out of reset, no requests
   // ST_RUN  | issuing fetches when buffer space allows
   // ST_HOLD | stalled, no new requests
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} state_t;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = 8;
   localparam logic [IW:0] DEPTH_W = (IW+1)'(FIFO_DEPTH);

   state_t r_state, w_state_nxt;

   logic [31:0]    r_fetch_pc;
   logic [IW-1:0]  r_inflight;
   logic [IW-1:0]  r_drop_cnt;

   logic [31:0]    r_fq_pc   [FIFO_DEPTH];
   logic [127:0]   r_fq_inst [FIFO_DEPTH];
   logic           r_fq_unc  [FIFO_DEPTH];
   logic [PW-1:0]  r_fq_rd, r_fq_wr;
   logic [CW-1:0]  r_fq_cnt;

   logic [31:0]    r_pq_pc   [FIFO_DEPTH];
   logic [PW-1:0]  r_pq_rd, r_pq_wr;
   logic [CW-1:0]  r_pq_cnt;

   logic           w_pr_redir, w_redir, w_ack, w_icv, w_drop_rsp, w_push, w_pop;
   logic [31:0]    w_redir_pc, w_head_pc, w_pq_head, w_ent1_pc;
   logic [IW-1:0]  w_live, w_inflight_nxt;
   logic [IW:0]    w_occ;

   assign w_pr_redir = pr_cancel & i_valid & i_ready;
   assign w_redir    = br_redirect | w_pr_redir;
   assign w_redir_pc = br_redirect ? br_target : pr_target;
   assign w_ack      = fe_req & fe_ack;
   // a response with nothing outstanding is stale (e.g. from before reset) and is ignored
   assign w_icv      = ic_valid & (r_inflight != '0);
   assign w_drop_rsp = w_icv & (w_redir | (r_drop_cnt != '0));
   assign w_push     = w_icv & ~w_drop_rsp;
   assign w_pop      = i_valid & i_ready;

   assign w_live         = r_inflight - r_drop_cnt;
   assign w_occ          = {{(IW+1-CW){1'b0}}, r_fq_cnt} + {1'b0, w_live};
   assign w_inflight_nxt = r_inflight + IW'(w_ack) - IW'(w_icv);

   assign w_head_pc = r_fq_pc[r_fq_rd];
   assign w_ent1_pc = r_fq_pc[r_fq_rd + PW'(1)];
   assign w_pq_head = r_pq_pc[r_pq_rd];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= ST_BOOT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN:  if (stall)  w_state_nxt = ST_HOLD;
         ST_HOLD: if (!stall) w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_BOOT;
      endcase
      if (w_redir) w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_fq_rd    <= '0;
         r_fq_wr    <= '0;
         r_fq_cnt   <= '0;
         r_pq_rd    <= '0;
         r_pq_wr    <= '0;
         r_pq_cnt   <= '0;
      end else if (w_redir) begin
         // everything still outstanding, including an ack taken this cycle, is stale
         r_fetch_pc <= w_redir_pc;
         r_inflight <= w_inflight_nxt;
         r_drop_cnt <= w_inflight_nxt;
         r_fq_rd    <= '0;
         r_fq_wr    <= '0;
         r_fq_cnt   <= '0;
         r_pq_rd    <= '0;
         r_pq_wr    <= '0;
         r_pq_cnt   <= '0;
      end else begin
         if (w_ack) r_fetch_pc <= {r_fetch_pc[31:4] + 28'd1, 4'h0};
         r_inflight <= w_inflight_nxt;
         if (w_drop_rsp) r_drop_cnt <= r_drop_cnt - IW'(1);
         if (w_push) r_fq_wr <= r_fq_wr + PW'(1);
         if (w_pop)  r_fq_rd <= r_fq_rd + PW'(1);
         r_fq_cnt <= r_fq_cnt + CW'(w_push) - CW'(w_pop);
         if (w_ack)  r_pq_wr <= r_pq_wr + PW'(1);
         if (w_push) r_pq_rd <= r_pq_rd + PW'(1);
         r_pq_cnt <= r_pq_cnt + CW'(w_ack) - CW'(w_push);
      end
   end

   // payload storage needs no reset: every read is qualified by the occupancy counts
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fq_pc[r_fq_wr]   <= w_pq_head;
         r_fq_inst[r_fq_wr] <= ic_inst;
         r_fq_unc[r_fq_wr]  <= ic_uncache;
      end
      if (w_ack && !w_redir) r_pq_pc[r_pq_wr] <= r_fetch_pc;
   end

   assign fe_req    = (r_state == ST_RUN) && (w_occ < DEPTH_W);
   assign fe_pc     = r_fetch_pc;
   assign i_valid   = (r_fq_cnt != '0);
   assign i_pc      = i_valid ? w_head_pc : 32'h0;
   assign i_inst    = i_valid ? r_fq_inst[r_fq_rd] : 128'h0;
   assign i_uncache = i_valid & r_fq_unc[r_fq_rd];
   assign i_count   = i_valid ? (2'h3 - w_head_pc[3:2]) : 2'h0;
   assign i_seq     = i_valid ? {w_head_pc[31:4] + 28'd1, 2'b00} : 30'h0;
   assign i_target  = (r_fq_cnt >= CW'(2)) ? w_ent1_pc[31:2] :
                      (r_pq_cnt != '0)     ? w_pq_head[31:2] : r_fetch_pc[31:2];
   assign i_is_seq  = i_valid && (i_target == i_seq);
   assign i_hint    = 16'h0000;

`ifdef GS232C_FETCH_PERF_EN
   logic [31:0] r_perf_req, r_perf_pkt, r_perf_drop, r_perf_redir;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_perf_req   <= '0;
         r_perf_pkt   <= '0;
         r_perf_drop  <= '0;
         r_perf_redir <= '0;
      end else begin
         if (w_ack)      r_perf_req   <= r_perf_req + 32'd1;
         if (w_pop)      r_perf_pkt   <= r_perf_pkt + 32'd1;
         if (w_drop_rsp) r_perf_drop  <= r_perf_drop + 32'd1;
         if (w_redir)    r_perf_redir <= r_perf_redir + 32'd1;
      end
   end

   assign perf_req_cnt      = r_perf_req;
   assign perf_pkt_cnt      = r_perf_pkt;
   assign perf_drop_cnt     = r_perf_drop;
   assign perf_redirect_cnt = r_perf_redir;
`endif

endmodule

// File: doc/gs232c_fetch_packer.md
GS232C_FETCH_PACKER -- requirements
Module: gs232c_fetch_packer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: packet buffer depth (power of two, 2..4).
REQ-003 SHALL have ports `clock` (in, 1) and `resetn` (in, 1); one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have fetch request ports `fe_req` (out, 1), `fe_pc` (out, 32, line-aligned to 16 B except after a redirect) and `fe_ack` (in, 1).
REQ-005 SHALL have cache return ports `ic_valid` (in, 1, in-order response), `ic_inst` (in, 128) and `ic_uncache` (in, 1).
REQ-006 SHALL have packet outputs `i_valid` (1), `i_pc` (32), `i_inst` (128), `i_count` (2), `i_seq` (30), `i_target` (30), `i_is_seq` (1), `i_uncache` (1) and `i_hint` (16), plus `i_ready` (in, 1).
REQ-007 SHALL have judge feedback inputs `pr_cancel` (1) and `pr_target` (32).
REQ-008 SHALL have backend redirect inputs `br_redirect` (1) and `br_target` (32), and `stall` (in, 1), which freezes new requests.

Function
REQ-009 SHALL implement the FSM BOOT->RUN after one cycle. RUN->HOLD when `stall`=1. HOLD->RUN when `stall`=0. Any state->RUN on a redirect.
REQ-010 SHALL drive `fe_req`=1 only in RUN, and only when `fifo_count` + `live_inflight` < FIFO_DEPTH; `fe_pc` SHALL equal `fetch_pc`.
REQ-011 On `fe_req`&&`fe_ack`, the block SHALL push `fetch_pc` into the pc queue, increment `inflight`, and set `fetch_pc` to {`fetch_pc`[31:4]+1, 4'h0}; the address wraps modulo 2^32.
REQ-012 On `ic_valid` with `drop_cnt`=0, the block SHALL push {pc-queue head, `ic_inst`, `ic_uncache`} into the FIFO; with `drop_cnt`>0 it SHALL discard the response and decrement `drop_cnt`.
REQ-013 `i_valid` SHALL be 1 whenever the FIFO is non-empty; the FIFO SHALL pop on `i_valid`&&`i_ready`; push and pop in the same cycle SHALL be legal when the FIFO is full.
REQ-014 `i_count` SHALL equal 2'h3 - `i_pc`[3:2], and `i_seq` SHALL equal {`i_pc`[31:4]+1, 2'b00}.
REQ-015 `i_target` SHALL equal the pc of FIFO entry 1 if present, else the pc-queue head if present, else `fetch_pc`[31:2]; `i_is_seq` SHALL be (`i_target` == `i_seq`).
REQ-016 `i_hint` SHALL be 16'h0000.
REQ-017 A pr redirect SHALL occur when `pr_cancel`&&`i_valid`&&`i_ready`: flush the FIFO, `fetch_pc`<=`pr_target`, `drop_cnt`<=`inflight` (excluding any response accepted that cycle), and clear the pc queue.
REQ-018 `br_redirect` SHALL perform the same action with `br_target` and SHALL override a simultaneous pr redirect.
REQ-019 An `ic_valid` arriving in a redirect cycle SHALL be dropped; an `fe_ack` arriving in a redirect cycle SHALL count as inflight-to-drop.
REQ-020 `i_valid` SHALL be 0 in the cycle after a redirect.

Reset
REQ-021 Asserting `resetn`=0 SHALL asynchronously set FSM=BOOT, `fetch_pc`=RESET_PC, FIFO empty, `inflight`=0 and `drop_cnt`=0; all outputs SHALL then read 0 except `fe_pc`=RESET_PC and `i_target`=RESET_PC[31:2].
REQ-022 Reset asserted mid-transfer SHALL discard all inflight state; responses arriving after reset release SHALL NOT be emitted until a new request is acked.

Configuration
REQ-023 Defining GS232C_FETCH_PERF_EN SHALL add 32-bit counters `perf_req_cnt`, `perf_pkt_cnt`, `perf_drop_cnt` and `perf_redirect_cnt`, each reset to 0 and incremented on its event.
REQ-024 Without GS232C_FETCH_PERF_EN, no counter logic SHALL exist and the port list SHALL be unchanged.

Verification
REQ-025 Release reset with `fe_ack`=1 and `ic_valid` one cycle later -> `fe_pc` sequence 1c000000, 1c000010; first packet has `i_pc`=1c000000, `i_count`=3, `i_seq`=0x07000004.
REQ-026 Hold `i_ready`=0 -> after two acks `fe_req`=0 and the FIFO holds 2 entries; release -> pops in order with no loss.
REQ-027 Redirect `pr_target`=1c000108 with 2 inflight -> next two `ic_valid` are dropped, next `fe_pc`=1c000108, and that packet has `i_count`=1.
REQ-028 Assert `br_redirect` (`br_target`=1c000200) in the same cycle as `pr_cancel` (`pr_target`=1c000300) -> `fetch_pc`=1c000200.
REQ-029 `fetch_pc`=fffffff0 acked -> next `fe_pc`=00000000 and `i_seq`=0.
REQ-030 Drive `resetn` low mid-burst -> outputs clear immediately; with GS232C_FETCH_PERF_EN defined, counters read 0.
